// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared frame layout, sequencer states and frame builder for the SPI command path.
// Also consumed by the driver-register layer so both sides agree on field positions.
package spi_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_NEXT,
    ST_RESP
  } state_e;

  localparam int FRAME_W    = 40;
  localparam int RW_BIT     = 39;
  localparam int ADDR_MSB   = 38;
  localparam int ADDR_LSB   = 32;
  localparam int DATA_MSB   = 31;
  localparam int STATUS_MSB = 39;
  localparam int STATUS_LSB = 32;
  localparam int TMO_W      = 16;

  // Reads carry an all-zero data field; only writes put payload on the wire.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic                       write,
    input logic [ADDR_MSB-ADDR_LSB:0] addr,
    input logic [DATA_MSB:0]          data
  );
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[RW_BIT]            = write;
    f[ADDR_MSB:ADDR_LSB] = addr;
    if (write) f[DATA_MSB:0] = data;
    return f;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous control bit.
// Adds two cycles of latency; no backpressure.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Turns one register request into one (write) or two (read) SPI master frames and a response strobe.
// Accepts a request only in IDLE; requests offered while busy are dropped, not queued.
module spi_cmd_sequencer
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int SIZE    = 40,
  parameter int CS_SIZE = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic                       req_valid_in,
  output logic                       req_ready_out,
  input  logic                       req_write_in,
  input  logic [6:0]                 req_addr_in,
  input  logic [31:0]                req_data_in,
  input  logic [$clog2(CS_SIZE)-1:0] req_cs_in,
  output logic                       resp_valid_out,
  output logic [31:0]                resp_data_out,
  output logic [7:0]                 resp_status_out,
  output logic                       resp_error_out,
  output logic [SIZE-1:0]            spi_data_out,
  output logic                       spi_send_enable_out,
  output logic [$clog2(CS_SIZE)-1:0] spi_cs_select_out,
  input  logic                       spi_ready_in,
  input  logic [SIZE-1:0]            spi_data_in
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  state_e                       state_q, state_d;
  logic                         write_q, write_d;
  logic                         frame_cnt_q, frame_cnt_d;
  logic                         gap_q, gap_d;
  logic                         err_q, err_d;
  logic [TMO_W-1:0]             tmo_q, tmo_d;
  logic [SIZE-1:0]              frame_q, frame_d;
  logic [$clog2(CS_SIZE)-1:0]   cs_q, cs_d;
  logic [SIZE-1:0]              cap_q, cap_d;
  logic                         rdy_sync;
  logic                         tmo_hit;

  sync_2ff u_rdy_sync (
    .clk_i  (clk_in),
    .rst_ni (reset_n_in),
    .d_i    (spi_ready_in),
    .q_o    (rdy_sync)
  );

  assign tmo_hit           = (tmo_q == TMO_MAX);
  assign spi_data_out      = frame_q;
  assign spi_cs_select_out = cs_q;

  always_comb begin
    state_d             = state_q;
    write_d             = write_q;
    frame_cnt_d         = frame_cnt_q;
    gap_d               = 1'b0;
    err_d               = err_q;
    tmo_d               = tmo_q;
    frame_d             = frame_q;
    cs_d                = cs_q;
    cap_d               = cap_q;
    req_ready_out       = 1'b0;
    spi_send_enable_out = 1'b0;
    resp_valid_out      = 1'b0;
    resp_data_out       = '0;
    resp_status_out     = '0;
    resp_error_out      = 1'b0;

    if (state_q == ST_START || state_q == ST_WAIT_LOW || state_q == ST_WAIT_HIGH) begin
      if (!tmo_hit) tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          write_d     = req_write_in;
          cs_d        = req_cs_in;
          frame_d     = SIZE'(build_frame(req_write_in, req_addr_in, req_data_in));
          frame_cnt_d = 1'b0;
          err_d       = 1'b0;
          cap_d       = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tmo_d = '0;
        if (rdy_sync) state_d = ST_START;
      end
      ST_START: begin
        spi_send_enable_out = 1'b1;
        state_d             = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        spi_send_enable_out = 1'b1;
        if (tmo_hit) begin
          spi_send_enable_out = 1'b0;
          err_d               = 1'b1;
          cap_d               = '0;
          state_d             = ST_RESP;
        end else if (!rdy_sync) begin
          state_d = ST_WAIT_HIGH;
        end
      end
      ST_WAIT_HIGH: begin
        spi_send_enable_out = 1'b1;
        if (tmo_hit) begin
          spi_send_enable_out = 1'b0;
          err_d               = 1'b1;
          cap_d               = '0;
          state_d             = ST_RESP;
        end else if (rdy_sync) begin
          spi_send_enable_out = 1'b0;
          cap_d               = spi_data_in;
          state_d             = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // Read data arrives one frame late, so a read repeats its address frame once.
        if (!write_q && !frame_cnt_q) begin
          gap_d = 1'b1;
          if (gap_q) begin
            frame_cnt_d = 1'b1;
            state_d     = ST_LOAD;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid_out  = 1'b1;
        resp_data_out   = cap_q[DATA_MSB:0];
        resp_status_out = cap_q[STATUS_MSB:STATUS_LSB];
        resp_error_out  = err_q;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      frame_cnt_q <= 1'b0;
      gap_q       <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      frame_q     <= '0;
      cs_q        <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      frame_cnt_q <= frame_cnt_d;
      gap_q       <= gap_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
      frame_q     <= frame_d;
      cs_q        <= cs_d;
      cap_q       <= cap_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench: stimulus pushes expected frames/responses, a slave model and a monitor pop and compare.
module tb_spi_cmd_sequencer;

  localparam int TMO = 100;

  typedef struct packed {
    logic [1:0]  cs;
    logic [39:0] dat;
  } frame_t;

  typedef struct packed {
    logic [7:0]  st;
    logic [31:0] dat;
    logic        err;
  } resp_t;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [6:0]  req_addr_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_cs_in;
  logic        resp_valid_out;
  logic [31:0] resp_data_out;
  logic [7:0]  resp_status_out;
  logic        resp_error_out;
  logic [39:0] spi_data_out;
  logic        spi_send_enable_out;
  logic [1:0]  spi_cs_select_out;
  logic        spi_ready_in;
  logic [39:0] spi_data_in;

  frame_t      exp_frame[$];
  resp_t       exp_resp[$];
  logic [39:0] slave_rsp[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  logic slave_en    = 1'b1;
  logic slave_hold  = 1'b0;
  logic slave_abort = 1'b0;

  spi_cmd_sequencer #(.SIZE(40), .CS_SIZE(4), .TIMEOUT(TMO)) dut (
    .clk_in              (clk_in),
    .reset_n_in          (reset_n_in),
    .req_valid_in        (req_valid_in),
    .req_ready_out       (req_ready_out),
    .req_write_in        (req_write_in),
    .req_addr_in         (req_addr_in),
    .req_data_in         (req_data_in),
    .req_cs_in           (req_cs_in),
    .resp_valid_out      (resp_valid_out),
    .resp_data_out       (resp_data_out),
    .resp_status_out     (resp_status_out),
    .resp_error_out      (resp_error_out),
    .spi_data_out        (spi_data_out),
    .spi_send_enable_out (spi_send_enable_out),
    .spi_cs_select_out   (spi_cs_select_out),
    .spi_ready_in        (spi_ready_in),
    .spi_data_in         (spi_data_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Pushes expectations, then offers the request and returns on the negedge after the handshake.
  task automatic issue(input logic w, input logic [6:0] a, input logic [31:0] d, input logic [1:0] cs,
                       input logic [39:0] frame, input int nframes,
                       input logic [39:0] r0, input logic [39:0] r1, input int nrsp,
                       input logic [7:0] est, input logic [31:0] edat, input logic eerr, input logic push_resp);
    int n;
    for (int i = 0; i < nframes; i++) exp_frame.push_back('{cs: cs, dat: frame});
    if (nrsp > 0) slave_rsp.push_back(r0);
    if (nrsp > 1) slave_rsp.push_back(r1);
    if (push_resp) exp_resp.push_back('{st: est, dat: edat, err: eerr});
    req_valid_in = 1'b1;
    req_write_in = w;
    req_addr_in  = a;
    req_data_in  = d;
    req_cs_in    = cs;
    n = 0;
    while (!req_ready_out && n < 300) begin
      @(negedge clk_in);
      n++;
    end
    if (!req_ready_out) fail("req_accept_timeout");
    @(negedge clk_in);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_resp.size() == 0 && req_ready_out) && n < 400) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 400) fail(name);
  endtask

  // SPI master/slave model: drops ready for a frame, returns queued data, checks frame contents.
  initial begin : slave
    frame_t ef, seen;
    spi_ready_in = 1'b1;
    spi_data_in  = '0;
    forever begin
      @(negedge clk_in);
      if (slave_en && spi_send_enable_out && spi_ready_in) begin
        seen = '{cs: spi_cs_select_out, dat: spi_data_out};
        if (exp_frame.size() == 0) fail("frame_unexpected");
        else begin
          ef = exp_frame.pop_front();
          check("frame_dat", seen.dat, ef.dat);
          check("frame_cs", seen.cs, ef.cs);
        end
        spi_ready_in = 1'b0;
        repeat (6) @(negedge clk_in);
        while (slave_hold) @(negedge clk_in);
        if (slave_abort) begin
          slave_abort  = 1'b0;
          spi_ready_in = 1'b1;
        end else begin
          check("frame_dat_stable", spi_data_out, seen.dat);
          check("frame_cs_stable", spi_cs_select_out, seen.cs);
          check("send_en_held", spi_send_enable_out, 1);
          spi_data_in  = (slave_rsp.size() != 0) ? slave_rsp.pop_front() : 40'h0;
          spi_ready_in = 1'b1;
        end
        for (int i = 0; i < 20 && spi_send_enable_out; i++) @(negedge clk_in);
      end
    end
  end

  initial begin : monitor
    resp_t e;
    logic  prev_v, prev_en, seen_en;
    int    low_run;
    prev_v  = 1'b0;
    prev_en = 1'b0;
    seen_en = 1'b0;
    low_run = 0;
    forever begin
      @(negedge clk_in);
      if (resp_valid_out) begin
        if (prev_v) fail("resp_pulse_width");
        if (exp_resp.size() == 0) fail("resp_unexpected");
        else begin
          e = exp_resp.pop_front();
          check("resp_status", resp_status_out, e.st);
          check("resp_data", resp_data_out, e.dat);
          check("resp_error", resp_error_out, e.err);
        end
      end
      prev_v = resp_valid_out;
      if (spi_send_enable_out) begin
        if (!prev_en && seen_en) check("send_en_gap_ge2", low_run >= 2, 1);
        seen_en = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      prev_en = spi_send_enable_out;
    end
  end

  initial begin : watchdog
    #400000;
    n_fail++;
    $display("FAIL watchdog expired");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin : stim
    int n, cnt;
    reset_n_in   = 1'b0;
    req_valid_in = 1'b0;
    req_write_in = 1'b0;
    req_addr_in  = '0;
    req_data_in  = '0;
    req_cs_in    = '0;
    repeat (3) @(negedge clk_in);
    check("rst_send_en", spi_send_enable_out, 0);
    check("rst_resp_valid", resp_valid_out, 0);
    check("rst_spi_data", spi_data_out, 0);
    check("rst_cs", spi_cs_select_out, 0);
    check("rst_resp_data", resp_data_out, 0);
    check("rst_resp_err", resp_error_out, 0);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    check("rst_req_ready", req_ready_out, 1);

    // Write 0x6C <- 0x00010203: single frame 0xEC00010203.
    issue(1'b1, 7'h6C, 32'h0001_0203, 2'd2, 40'hEC_0001_0203, 1,
          40'h11_2233_4455, 40'h0, 1, 8'h11, 32'h2233_4455, 1'b0, 1'b1);
    req_valid_in = 1'b0;
    wait_idle("write_done_timeout");

    // Read 0x6F: two frames 0x6F00000000, result from the second.
    issue(1'b0, 7'h6F, 32'hFFFF_FFFF, 2'd1, 40'h6F_0000_0000, 2,
          40'h55_0000_000A, 40'h77_DEAD_BEEF, 2, 8'h77, 32'hDEAD_BEEF, 1'b0, 1'b1);
    req_valid_in = 1'b0;
    wait_idle("read_done_timeout");

    // Timeout: slave never drops ready.
    slave_en = 1'b0;
    issue(1'b1, 7'h01, 32'h1234_5678, 2'd0, 40'h0, 0,
          40'h0, 40'h0, 0, 8'h00, 32'h0, 1'b1, 1'b1);
    req_valid_in = 1'b0;
    n = 0;
    while (!spi_send_enable_out && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    cnt = 0;
    while (spi_send_enable_out && cnt < 300) begin
      cnt++;
      @(negedge clk_in);
    end
    check("timeout_send_en_len", (cnt <= TMO) && (cnt >= TMO - 1), 1);
    wait_idle("timeout_resp_timeout");
    slave_en = 1'b1;

    // Back-to-back writes with valid held high.
    issue(1'b1, 7'h10, 32'hCAFE_0001, 2'd1, 40'h90_CAFE_0001, 1,
          40'hA1_0000_0001, 40'h0, 1, 8'hA1, 32'h0000_0001, 1'b0, 1'b1);
    issue(1'b1, 7'h11, 32'hCAFE_0002, 2'd2, 40'h91_CAFE_0002, 1,
          40'hA2_0000_0002, 40'h0, 1, 8'hA2, 32'h0000_0002, 1'b0, 1'b1);
    issue(1'b1, 7'h12, 32'hCAFE_0003, 2'd3, 40'h92_CAFE_0003, 1,
          40'hA3_0000_0003, 40'h0, 1, 8'hA3, 32'h0000_0003, 1'b0, 1'b1);
    req_valid_in = 1'b0;
    wait_idle("b2b_done_timeout");

    // Reset while the frame is running: no response for the aborted write.
    slave_hold = 1'b1;
    issue(1'b1, 7'h7F, 32'hFFFF_FFFF, 2'd3, 40'hFF_FFFF_FFFF, 1,
          40'h0, 40'h0, 0, 8'h00, 32'h0, 1'b0, 1'b0);
    req_valid_in = 1'b0;
    n = 0;
    while (spi_ready_in && n < 60) begin
      @(negedge clk_in);
      n++;
    end
    repeat (5) @(negedge clk_in);
    check("wait_high_send_en", spi_send_enable_out, 1);
    #2 reset_n_in = 1'b0;
    #1;
    check("midrst_send_en", spi_send_enable_out, 0);
    check("midrst_resp_valid", resp_valid_out, 0);
    slave_abort = 1'b1;
    slave_hold  = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_n_in = 1'b1;
    @(negedge clk_in);
    check("postrst_req_ready", req_ready_out, 1);

    issue(1'b1, 7'h05, 32'h1234_5678, 2'd0, 40'h85_1234_5678, 1,
          40'h5A_8765_4321, 40'h0, 1, 8'h5A, 32'h8765_4321, 1'b0, 1'b1);
    req_valid_in = 1'b0;
    wait_idle("postrst_done_timeout");
    repeat (10) @(negedge clk_in);

    check("frames_left", exp_frame.size(), 0);
    check("resps_left", exp_resp.size(), 0);
    check("slave_rsp_left", slave_rsp.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 40: SPI frame width in bits, {rw, addr[6:0], data[31:0]}.
REQ-002 SHALL have parameter CS_SIZE, default 4: number of chip selects on the downstream SPI master.
REQ-003 SHALL have parameter TIMEOUT, default 65535: clk_in cycles allowed per SPI frame before abort.
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports named clk_in and reset_n_in.
REQ-005 Ports, as name direction width meaning:
- clk_in  in  1  system clock
- reset_n_in  in  1  async active-low reset
- req_valid_in  in  1  request offered
- req_ready_out  out  1  request accepted when high together with req_valid_in
- req_write_in  in  1  1=write, 0=read
- req_addr_in  in  7  register address
- req_data_in  in  32  write data; ignored for reads
- req_cs_in  in  $clog2(CS_SIZE)  target chip select
- resp_valid_out  out  1  one-cycle response strobe
- resp_data_out  out  32  read data; for writes, the data returned during the write frame
- resp_status_out  out  8  first returned byte (driver status)
- resp_error_out  out  1  timeout occurred
- spi_data_out  out  SIZE  frame to SPI master data_in
- spi_send_enable_out  out  1  to SPI master send_enable_in
- spi_cs_select_out  out  $clog2(CS_SIZE)  to SPI master cs_select_in
- spi_ready_in  in  1  from SPI master r_ready_out
- spi_data_in  in  SIZE  from SPI master data_out

Function
REQ-006 SHALL pass spi_ready_in through a 2-flop synchronizer and use only the synchronized value.
REQ-007 SHALL implement the states IDLE, LOAD, START, WAIT_LOW, WAIT_HIGH, NEXT, RESP.
REQ-008 IDLE: req_ready_out=1; on req_valid_in, latch write, addr, data and cs, clear the frame counter, go to LOAD.
REQ-009 LOAD: spi_data_out={write,addr,data}, or {0,addr,32'h0} for a read; spi_cs_select_out=latched cs; wait until the synchronized ready is 1, then go to START.
REQ-010 START/WAIT_LOW: assert spi_send_enable_out; wait for synchronized ready=0 (frame running).
REQ-011 WAIT_HIGH: keep send_enable asserted until synchronized ready returns to 1; deassert it in that same cycle, capture spi_data_in, go to NEXT.
REQ-012 A read takes two frames, because read data returns one frame late: frame 0 sends the read address; frame 1 repeats it, and its capture is the result. A write takes one frame.
REQ-013 NEXT: if another frame is required, hold send_enable low for at least 2 cycles, then go to LOAD; otherwise go to RESP.
REQ-014 RESP: resp_valid_out=1 for exactly one cycle; resp_status_out=capture[39:32]; resp_data_out=capture[31:0]; return to IDLE.
REQ-015 A 16-bit timeout counter SHALL reset on entry to START and saturate at TIMEOUT. Reaching TIMEOUT in WAIT_LOW or WAIT_HIGH SHALL deassert send_enable and go to RESP with resp_error_out=1 and data/status of 0.
REQ-016 req_valid_in arriving outside IDLE SHALL be ignored (req_ready_out=0); no queuing.
REQ-017 spi_data_out and spi_cs_select_out SHALL stay stable from LOAD until send_enable deasserts.

Reset
REQ-018 Reset SHALL force state IDLE, req_ready_out=1 after release, and all other outputs, synchronizer and counters to 0.
REQ-019 Reset mid-frame SHALL drop spi_send_enable_out immediately; no response is emitted for the aborted request.

Structure
REQ-020 State encodings, the frame field offsets (RW bit 39, ADDR 38:32, DATA 31:0) and the STATUS byte position SHALL live in a shared package also used by the driver-register layer.
REQ-021 The synchronizer SHALL be the sub-module sync_2ff; the rest stays flat.

Verification
REQ-022 Write: addr 0x6C, data 0x00010203 -> one 40-bit frame 0xEC00010203, CS stays low for the whole frame, one resp_valid pulse, error=0.
REQ-023 Read: addr 0x6F; SPI slave model returns 0x55_0000000A then 0x77_DEADBEEF -> two frames 0x6F00000000; resp_data=0xDEADBEEF, resp_status=0x77.
REQ-024 Timeout: spi_ready_in held 1 after START, TIMEOUT=100 -> send_enable drops by cycle 100, resp_error=1, data=0.
REQ-025 Back-to-back: req_valid held high for 3 writes -> 3 responses in order; send_enable low for at least 2 cycles between frames.
REQ-026 Reset asserted in WAIT_HIGH -> send_enable=0 and resp_valid=0 at once; after release, a new write completes normally.
